// File: rtl/mult_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_product_accumulator_if
// Description : Term-input and result-output handshake bundle for the
//               product accumulator. Master = producer/consumer side,
//               slave = the accumulator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_product_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 8
);
  // Term side
  logic [PROD_W-1:0] prod_in;
  logic              prod_signed;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  // Result side
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prod_in, prod_signed, len, in_valid, out_ready,
    input  in_ready, acc_out, overflow, out_valid
  );

  modport slave (
    input  prod_in, prod_signed, len, in_valid, out_ready,
    output in_ready, acc_out, overflow, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mult_product_accumulator
// Description : Accumulates a programmable number of multiplier products
//               into an ACC_W-bit sum and presents one result per block
//               through a valid/ready output register with a sticky
//               per-block overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 8
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  mult_product_accumulator_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Block state
  logic [ACC_W-1:0] acc_q,        acc_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] blk_len_q,    blk_len_d;
  logic             blk_signed_q, blk_signed_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  // Output register
  logic [ACC_W-1:0] acc_out_q,    acc_out_d;
  logic             overflow_q,   overflow_d;
  logic             out_valid_q,  out_valid_d;

  // Datapath wires
  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_signed_eff;
  logic [CNT_W-1:0] w_len_first;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_unsigned;
  logic             w_ovf_signed;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_new_acc;
  logic             w_new_ovf;

  // The only combinational path to an output: out_ready -> in_ready.
  // A stalled result blocks all intake, mid-block terms included.
  assign w_in_ready = !reset && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // An idle block (cnt == 0) takes its mode and length from the term being
  // accepted; after that the latched copies are authoritative.
  assign w_first      = (cnt_q == CNT_ZERO);
  assign w_signed_eff = w_first ? bus.prod_signed : blk_signed_q;
  assign w_len_first  = (bus.len == CNT_ZERO) ? CNT_ONE : bus.len;
  assign w_len_eff    = w_first ? w_len_first : blk_len_q;
  assign w_cnt_inc    = cnt_q + CNT_ONE;
  assign w_last       = (w_cnt_inc == w_len_eff);

  // Extend the product to accumulator width; no padding needed when the
  // widths match.
  generate
    if (ACC_W > PROD_W) begin : g_ext_pad
      assign w_ext = {{(ACC_W-PROD_W){w_signed_eff & bus.prod_in[PROD_W-1]}},
                      bus.prod_in};
    end else begin : g_ext_none
      assign w_ext = bus.prod_in[ACC_W-1:0];
    end
  endgenerate

  // One extra bit captures the unsigned carry out of the accumulator MSB.
  assign w_sum = {1'b0, acc_q} + {1'b0, w_ext};

  assign w_ovf_unsigned = w_sum[ACC_W];
  assign w_ovf_signed   = (acc_q[ACC_W-1] == w_ext[ACC_W-1]) &&
                          (w_sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign w_add_ovf      = blk_signed_q ? w_ovf_signed : w_ovf_unsigned;

  // The first term loads rather than adds, so it can never overflow.
  assign w_new_acc = w_first ? w_ext : w_sum[ACC_W-1:0];
  assign w_new_ovf = w_first ? 1'b0 : (ovf_sticky_q | w_add_ovf);

  // Next-state for block accumulation and the output register.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    blk_len_d    = blk_len_q;
    blk_signed_d = blk_signed_q;
    ovf_sticky_d = ovf_sticky_q;
    acc_out_d    = acc_out_q;
    overflow_d   = overflow_q;
    out_valid_d  = out_valid_q;

    // Consumption first so that a same-cycle completion overrides it.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      acc_d        = w_new_acc;
      ovf_sticky_d = w_new_ovf;
      if (w_first) begin
        blk_signed_d = bus.prod_signed;
        blk_len_d    = w_len_first;
      end
      if (w_last) begin
        cnt_d       = CNT_ZERO;
        acc_out_d   = w_new_acc;
        overflow_d  = w_new_ovf;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = w_cnt_inc;
      end
    end
  end

  // State registers; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      cnt_q        <= CNT_ZERO;
      blk_len_q    <= CNT_ONE;
      blk_signed_q <= 1'b0;
      ovf_sticky_q <= 1'b0;
      acc_out_q    <= '0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      blk_len_q    <= blk_len_d;
      blk_signed_q <= blk_signed_d;
      ovf_sticky_q <= ovf_sticky_d;
      acc_out_q    <= acc_out_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.acc_out   = acc_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_product_accumulator
// Description : Bench for the product accumulator. Two instances (48-bit and
//               34-bit accumulators) receive identical stimulus; directed
//               scenarios plus a randomized run against a block-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] prod;
  logic        sgn;
  logic [7:0]  len;
  logic        iv;
  logic        ordy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_product_accumulator_if #(.PROD_W(32), .ACC_W(48), .CNT_W(8)) u48 ();
  mult_product_accumulator_if #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) u34 ();

  assign u48.prod_in = prod;  assign u34.prod_in = prod;
  assign u48.prod_signed = sgn; assign u34.prod_signed = sgn;
  assign u48.len = len;       assign u34.len = len;
  assign u48.in_valid = iv;   assign u34.in_valid = iv;
  assign u48.out_ready = ordy; assign u34.out_ready = ordy;

  mult_product_accumulator #(.PROD_W(32), .ACC_W(48), .CNT_W(8)) dut48 (
    .clk(clk), .reset(reset), .bus(u48.slave));
  mult_product_accumulator #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) dut34 (
    .clk(clk), .reset(reset), .bus(u34.slave));

  // Reference model: terms of the open block and the held result.
  logic [31:0] m_terms[$];
  bit          m_sign;
  int          m_len;
  bit          m_out_valid;
  logic [63:0] m_res48, m_res34;
  bit          m_ovf48, m_ovf34;

  // Block sum from the plain integer running total; overflow is any
  // intermediate total leaving the representable range.
  task automatic block_result(input int accw, output logic [63:0] res, output bit ovf);
    longint s = 0;
    longint lim_s = longint'(1) << (accw - 1);
    longint lim_u = longint'(1) << accw;
    ovf = 1'b0;
    foreach (m_terms[i]) begin
      if (m_sign) s += longint'($signed(m_terms[i]));
      else        s += longint'({32'd0, m_terms[i]});
      if (i > 0) begin
        if (m_sign && (s >= lim_s || s < -lim_s)) ovf = 1'b1;
        if (!m_sign && s >= lim_u) ovf = 1'b1;
      end
    end
    res = 64'(s) & ((64'd1 << accw) - 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit s,
                       input logic [7:0] l, input bit r);
    iv = v; prod = p; sgn = s; len = l; ordy = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h1234, 1'b0, 8'd1, 1'b1);
    tick(); tick();
    checks++; if (u48.acc_out !== 48'd0 || u34.acc_out !== 34'd0) begin
      errors++; $display("FAIL reset_acc: got %h/%h expected 0", u48.acc_out, u34.acc_out); end
    checks++; if (u48.out_valid !== 1'b0 || u48.overflow !== 1'b0 || u34.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v=%b o=%b expected 0", u48.out_valid, u48.overflow); end
    checks++; if (u48.in_ready !== 1'b0 || u34.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", u48.in_ready); end
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hFFFE0001, 1'b0, 8'd4, 1'b1);
      tick();
      if (i < 3) begin
        checks++; if (u48.out_valid !== 1'b0) begin
          errors++; $display("FAIL uns_early_valid: got %b expected 0 (term %0d)", u48.out_valid, i); end
      end
    end
    drive(1'b0, 32'd0, 1'b0, 8'd4, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'h0003FFF80004 || u48.overflow !== 1'b0) begin
      errors++; $display("FAIL uns_result48: got v=%b %h o=%b expected 1 0003fff80004 0", u48.out_valid, u48.acc_out, u48.overflow); end
    checks++; if (u34.acc_out !== 34'h3FFF80004 || u34.overflow !== 1'b0) begin
      errors++; $display("FAIL uns_result34: got %h o=%b expected 3fff80004 0", u34.acc_out, u34.overflow); end
    tick();
    checks++; if (u48.out_valid !== 1'b0) begin
      errors++; $display("FAIL uns_one_cycle: got %b expected 0", u48.out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hFFFE0001, 1'b0, 8'd5, 1'b1);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    checks++; if (u34.out_valid !== 1'b1 || u34.acc_out !== 34'h0FFF60005 || u34.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_result34: got v=%b %h o=%b expected 1 0fff60005 1", u34.out_valid, u34.acc_out, u34.overflow); end
    checks++; if (u48.acc_out !== 48'h0004FFF60005 || u48.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_result48: got %h o=%b expected 0004fff60005 0", u48.acc_out, u48.overflow); end
    tick();
  endtask

  task automatic test_signed();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0008000, 1'b1, 8'd3, 1'b1);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'hFFFF40018000 || u48.overflow !== 1'b0) begin
      errors++; $display("FAIL sgn_result48: got v=%b %h o=%b expected 1 ffff40018000 0", u48.out_valid, u48.acc_out, u48.overflow); end
    checks++; if (u34.acc_out !== 34'h340018000 || u34.overflow !== 1'b0) begin
      errors++; $display("FAIL sgn_result34: got %h o=%b expected 340018000 0", u34.acc_out, u34.overflow); end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'd5, 1'b0, 8'd1, 1'b0);
    tick();
    drive(1'b1, 32'd7, 1'b0, 8'd1, 1'b0);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'd5) begin
      errors++; $display("FAIL bp_first: got v=%b %h expected 1 5", u48.out_valid, u48.acc_out); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (u48.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready: got %b expected 0 (cycle %0d)", u48.in_ready, i); end
      tick();
      checks++; if (u48.acc_out !== 48'd5 || u48.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold: got v=%b %h expected 1 5", u48.out_valid, u48.acc_out); end
    end
    ordy = 1'b1;
    #1;
    checks++; if (u48.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %b expected 1", u48.in_ready); end
    tick();
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'd7) begin
      errors++; $display("FAIL bp_second: got v=%b %h expected 1 7", u48.out_valid, u48.acc_out); end
    tick();
    checks++; if (u48.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b expected 0", u48.out_valid); end
  endtask

  task automatic test_len_rules();
    drive(1'b1, 32'd9, 1'b0, 8'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 8'd0, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'd9) begin
      errors++; $display("FAIL len0: got v=%b %h expected 1 9", u48.out_valid, u48.acc_out); end
    tick();
    drive(1'b1, 32'd1, 1'b0, 8'd3, 1'b1);
    tick();
    drive(1'b1, 32'd2, 1'b1, 8'd1, 1'b1);
    tick();
    checks++; if (u48.out_valid !== 1'b0) begin
      errors++; $display("FAIL len_change_early: got %b expected 0", u48.out_valid); end
    drive(1'b1, 32'd3, 1'b1, 8'd1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'd6) begin
      errors++; $display("FAIL len_change: got v=%b %h expected 1 6", u48.out_valid, u48.acc_out); end
    tick();
  endtask

  task automatic test_reset_midblock();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'd100, 1'b0, 8'd4, 1'b1);
      tick();
    end
    reset = 1'b1;
    #1;
    checks++; if (u48.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", u48.in_ready); end
    tick();
    checks++; if (u48.out_valid !== 1'b0 || u48.acc_out !== 48'd0 || u48.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got v=%b %h r=%b expected 0 0 0", u48.out_valid, u48.acc_out, u48.in_ready); end
    reset = 1'b0;
    drive(1'b1, 32'd1, 1'b0, 8'd2, 1'b1);
    tick();
    drive(1'b1, 32'd2, 1'b0, 8'd2, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    checks++; if (u48.out_valid !== 1'b1 || u48.acc_out !== 48'd3) begin
      errors++; $display("FAIL rst_mid_next: got v=%b %h expected 1 3", u48.out_valid, u48.acc_out); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] picks [4];
    bit          m_in_ready;
    bit          acc;
    picks[0] = 32'hFFFFFFFF; picks[1] = 32'h80000000;
    picks[2] = 32'h7FFFFFFF; picks[3] = 32'hFFFE0001;
    m_terms.delete();
    m_out_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7,
            ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 3)] : 32'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)),
            $urandom_range(0, 9) < 6);
      #1;
      m_in_ready = !m_out_valid || ordy;
      checks++; if (u48.in_ready !== m_in_ready || u34.in_ready !== m_in_ready) begin
        errors++; $display("FAIL rnd_in_ready: got %b/%b expected %b (cycle %0d)", u48.in_ready, u34.in_ready, m_in_ready, c); end
      checks++; if (u48.out_valid !== m_out_valid || u34.out_valid !== m_out_valid) begin
        errors++; $display("FAIL rnd_out_valid: got %b/%b expected %b (cycle %0d)", u48.out_valid, u34.out_valid, m_out_valid, c); end
      if (m_out_valid) begin
        checks++; if (u48.acc_out !== m_res48[47:0] || u48.overflow !== m_ovf48) begin
          errors++; $display("FAIL rnd_result48: got %h o=%b expected %h o=%b (cycle %0d)", u48.acc_out, u48.overflow, m_res48[47:0], m_ovf48, c); end
        checks++; if (u34.acc_out !== m_res34[33:0] || u34.overflow !== m_ovf34) begin
          errors++; $display("FAIL rnd_result34: got %h o=%b expected %h o=%b (cycle %0d)", u34.acc_out, u34.overflow, m_res34[33:0], m_ovf34, c); end
      end
      acc = iv && m_in_ready;
      if (m_out_valid && ordy) m_out_valid = 1'b0;
      if (acc) begin
        if (m_terms.size() == 0) begin
          m_sign = sgn;
          m_len  = (len == 8'd0) ? 1 : int'(len);
        end
        m_terms.push_back(prod);
        if (m_terms.size() == m_len) begin
          block_result(48, m_res48, m_ovf48);
          block_result(34, m_res34, m_ovf34);
          m_out_valid = 1'b1;
          m_terms.delete();
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0, 8'd1, 1'b1);
    reset = 1'b1;
    test_reset();
    test_unsigned();
    test_overflow();
    test_signed();
    test_backpressure();
    test_len_rules();
    test_reset_midblock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
